lcd_bus_arbiter: RTL and testbench
==================================

# lcd_bus_arbiter

Shares one HD44780-style character LCD (8-bit, write-only) between NREQ command sources: menu text generator, status writer and Wishbone CPU port. After reset it runs the panel power-up init sequence. It then arbitrates round-robin between requesters, with an optional lock so a multi-byte string is never interleaved. It drives the panel with correct RS/E setup, pulse and hold timing, and waits out each command's execution time.

## Interface
Parameters:
- NREQ, 3: number of requesters (2..8).
- T_SETUP, 2: clk2 cycles from RS/DB valid to E rise.
- T_EN, 12: E high width, in cycles.
- T_HOLD, 2: cycles that DB/RS are held after E falls.
- T_SHORT, 2000: execution wait for ordinary commands and data.
- T_LONG, 80000: execution wait for clear/home.
- T_PWRUP, 300000: wait after reset before the first init command.
- CNT_W, 19: width of the delay counter. It must hold the largest T_*.

Ports:
- clk2, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- req, in, NREQ: per-requester command pending.
- lock, in, NREQ: the owner keeps the bus after its current command.
- rs, in, NREQ: 0 = instruction, 1 = data.
- data, in, 8*NREQ: command byte. Requester k uses bits [8k+7:8k].
- ack, out, NREQ: one-cycle pulse when requester k's command is captured.
- grant, out, NREQ: one-hot, marks the current/last owner; 0 when none.
- busy, out, 1: high except in IDLE with init done.
- lcd_rs, out, 1: panel RS.
- lcd_rw, out, 1: panel R/W, constant 0.
- lcd_e, out, 1: panel enable strobe.
- lcd_db, out, 8: panel data bus.

## Operation
- States:
  - INIT_WAIT: T_PWRUP countdown.
  - INIT_ISSUE: sends init ROM entry i.
  - IDLE.
  - SETUP: T_SETUP cycles.
  - PULSE: T_EN cycles, lcd_e=1.
  - HOLD: T_HOLD cycles.
  - WAIT: T_SHORT or T_LONG cycles.
- Init ROM, always rs=0: 0x38, 0x38, 0x0C, 0x06, 0x01.
  - Each entry runs SETUP→PULSE→HOLD→WAIT, then returns to INIT_ISSUE.
  - After the last entry: IDLE, busy=0.
  - No acks are issued during init, and grant=0.
- IDLE selection:
  - If the current owner has lock=1, only that owner is eligible. Other req lines stall, even if the owner's req=0.
  - Otherwise, round-robin: search from (last+1) mod NREQ upward and take the first set req. last resets to NREQ-1, so req[0] wins first.
- Capture: in the selection cycle, ack[k]=1, rs[k]/data[k] are latched, grant=one-hot(k), last=k, then go to SETUP.
- Requester rules:
  - Hold req/rs/data stable until ack.
  - Drop req, or present the next byte, in the ack cycle.
  - Deassert lock on or before its final byte's req.
- Wait selection: T_LONG if the latched rs=0 and data ∈ {0x01, 0x02, 0x03}; otherwise T_SHORT.
- lcd_rs/lcd_db are driven from the latched command from SETUP through WAIT. They keep their last value in IDLE.
- A single down-counter (CNT_W bits) is loaded on each state entry with (T_x − 1) and the state advances at 0. A T_x of 1 means one cycle.

## Timing
- Reset values, taking effect on the next clk2 edge with rst=1:
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00.
  - ack=0, grant=0, busy=1.
  - State INIT_WAIT, last=NREQ-1.
- rst during any state aborts the cycle: E goes low at that edge and init restarts in full.
- With ack in cycle N:
  - SETUP covers N+1 .. N+T_SETUP.
  - lcd_e=1 for N+T_SETUP+1 .. N+T_SETUP+T_EN.
  - HOLD follows, then WAIT.
  - IDLE is re-entered in cycle N+T_SETUP+T_EN+T_HOLD+Twait+1.
  - The earliest next ack is that cycle.
- Default ordinary-command throughput: 1+2+12+2+2000 = 2017 cycles per byte.
- busy=0 only in IDLE after init. busy rises combinationally with ack.
- A req that rises while busy waits for IDLE. Simultaneous reqs resolve round-robin, and exactly one ack is pulsed.

## Structure
- Shared package lcd_pkg:
  - HD44780 opcode constants (CLEAR 0x01, HOME 0x02, ENTRY 0x06, DISP_ON 0x0C, FSET_8B2L 0x38, SET_DDRAM 0x80).
  - The state enum.
  - The init ROM array and its length.
- Sub-module lcd_rr_pick: combinational round-robin selector (req, last, lock_owner → one-hot pick, valid). It is reused by the Wishbone LCD wrapper.

## Test plan
- Power-up: release rst → no lcd_e for T_PWRUP cycles, then five E pulses carrying 0x38, 0x38, 0x0C, 0x06, 0x01 with rs=0; busy falls after the 0x01 T_LONG wait.
- Single data write: req[1], rs=1, data=0x48 → ack[1] in one cycle; lcd_e high exactly T_EN cycles starting T_SETUP+1 after ack; lcd_db=0x48 through HOLD; next ack ≥2017 cycles later.
- Contention: req[0], req[1] and req[2] all high after init → acks in order 0, 1, 2, 0 …
- Lock: requester 2 sends "ABC" with lock=1 while req[0]=1 → 0x41, 0x42, 0x43 on the bus consecutively; ack[0] only after lock[2]=0.
- Long wait: rs=0, data=0x01 → T_LONG wait; data=0x80 → T_SHORT wait.
- Reset mid-PULSE: assert rst while lcd_e=1 → lcd_e=0 at the next edge, no ack, grant=0, and the init sequence reruns in full.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions: opcodes, controller state encoding and the
// power-up init ROM used by the LCD bus arbiter and its wrappers.
package lcd_pkg;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_FSET_8B2L = 8'h38;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_INIT_ISSUE,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_state_t;

    localparam int INIT_LEN = 5;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        CMD_FSET_8B2L, CMD_FSET_8B2L, CMD_DISP_ON, CMD_ENTRY, CMD_CLEAR
    };

    // Clear and both home encodings (0x02/0x03) need the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] db);
        return !rs && (db == CMD_CLEAR || db == CMD_HOME || db == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin selector: searches upward from last+1, or
// restricts the choice to the locked owner when lock_owner is set.
module lcd_rr_pick #(
    parameter  int NREQ  = 3,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    input  logic             lock_owner,
    output logic [NREQ-1:0]  pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        pick     = '0;
        pick_idx = last;
        valid    = 1'b0;
        cand     = last;
        if (lock_owner) begin
            valid = req[last];
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                cand = (cand == IDX_W'(NREQ - 1)) ? '0 : cand + 1'b1;
                if (!valid && req[cand]) begin
                    valid    = 1'b1;
                    pick_idx = cand;
                end
            end
        end
        if (valid) pick[pick_idx] = 1'b1;
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one write-only HD44780 panel between NREQ command sources: runs the
// power-up init, then arbitrates round-robin with optional per-owner lock.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_SHORT = 2000,
    parameter int T_LONG  = 80000,
    parameter int T_PWRUP = 300000,
    parameter int CNT_W   = 19
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ-1:0]   rs,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_e,
    output logic [7:0]        lcd_db
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int IW    = $clog2(INIT_LEN);

    lcd_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] last;
    logic [IW-1:0]    init_idx;
    logic             init_done;
    logic             lock_hold;
    logic [NREQ-1:0]  pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             sel_rs;
    logic [7:0]       sel_db;
    logic             cnt_zero;

    lcd_rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req),
        .last       (last),
        .lock_owner (lock_hold),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .valid      (pick_valid)
    );

    always_comb begin
        sel_rs = 1'b0;
        sel_db = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick[k]) begin
                sel_rs = rs[k];
                sel_db = data[8*k +: 8];
            end
        end
    end

    assign cnt_zero = (cnt == '0);
    assign ack      = (state == ST_IDLE && !rst && pick_valid) ? pick : '0;
    assign busy     = (state != ST_IDLE) || (|ack);
    assign lcd_rw   = 1'b0;

    // Every timed state is entered with its count minus one and leaves at zero.
    always_ff @(posedge clk2) begin
        if (rst) begin
            state     <= ST_INIT_WAIT;
            cnt       <= CNT_W'(T_PWRUP - 1);
            last      <= IDX_W'(NREQ - 1);
            init_idx  <= '0;
            init_done <= 1'b0;
            lock_hold <= 1'b0;
            grant     <= '0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_db    <= '0;
        end else begin
            if (!cnt_zero) cnt <= cnt - 1'b1;
            unique case (state)
                ST_INIT_WAIT: if (cnt_zero) state <= ST_INIT_ISSUE;
                ST_INIT_ISSUE: begin
                    lcd_rs <= 1'b0;
                    lcd_db <= INIT_ROM[init_idx];
                    cnt    <= CNT_W'(T_SETUP - 1);
                    state  <= ST_SETUP;
                end
                ST_IDLE: if (pick_valid) begin
                    lcd_rs    <= sel_rs;
                    lcd_db    <= sel_db;
                    grant     <= pick;
                    last      <= pick_idx;
                    lock_hold <= |(lock & pick);
                    cnt       <= CNT_W'(T_SETUP - 1);
                    state     <= ST_SETUP;
                end
                ST_SETUP: if (cnt_zero) begin
                    lcd_e <= 1'b1;
                    cnt   <= CNT_W'(T_EN - 1);
                    state <= ST_PULSE;
                end
                ST_PULSE: if (cnt_zero) begin
                    lcd_e <= 1'b0;
                    cnt   <= CNT_W'(T_HOLD - 1);
                    state <= ST_HOLD;
                end
                ST_HOLD: if (cnt_zero) begin
                    cnt   <= is_long_cmd(lcd_rs, lcd_db) ? CNT_W'(T_LONG - 1) : CNT_W'(T_SHORT - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: if (cnt_zero) begin
                    if (init_done) begin
                        state <= ST_IDLE;
                    end else if (init_idx == IW'(INIT_LEN - 1)) begin
                        init_done <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        init_idx <= init_idx + 1'b1;
                        state    <= ST_INIT_ISSUE;
                    end
                end
                default: state <= ST_INIT_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter with shortened panel timings.
module tb_lcd_bus_arbiter;

    localparam int NREQ = 3;
    localparam int TS   = 2;
    localparam int TE   = 3;
    localparam int TH   = 2;
    localparam int TSH  = 10;
    localparam int TL   = 30;
    localparam int TPW  = 20;
    localparam int CW   = 8;
    localparam int SHORT_ENTRY = 1 + TS + TE + TH + TSH;
    localparam int LONG_ENTRY  = 1 + TS + TE + TH + TL;

    logic              clk2 = 1'b0;
    logic              rst  = 1'b1;
    logic [NREQ-1:0]   req  = '0;
    logic [NREQ-1:0]   lock = '0;
    logic [NREQ-1:0]   rs   = '0;
    logic [8*NREQ-1:0] data = '0;
    logic [NREQ-1:0]   ack, grant;
    logic              busy, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]        lcd_db;

    lcd_bus_arbiter #(
        .NREQ(NREQ), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH),
        .T_SHORT(TSH), .T_LONG(TL), .T_PWRUP(TPW), .CNT_W(CW)
    ) dut (
        .clk2(clk2), .rst(rst), .req(req), .lock(lock), .rs(rs), .data(data),
        .ack(ack), .grant(grant), .busy(busy), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_db(lcd_db)
    );

    always #5 clk2 = ~clk2;

    typedef struct packed { logic rs; logic [7:0] db; } bus_t;
    bus_t exp_bus[$];
    int   exp_ack[$];

    int   checks = 0, errors = 0;
    int   cyc = 0, n_acks = 0, t_busy_fall = 0, e_cnt = 0, mon_k;
    bus_t mon_b;
    logic e_prev = 1'b0, busy_prev = 1'b1;

    always @(posedge clk2) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout at cycle %0d", name, cyc);
    endtask

    // Monitor: pops expected acks and bus bytes as the DUT presents them.
    always @(negedge clk2) begin
        if (ack != '0) begin
            n_acks++;
            if (exp_ack.size() == 0) begin
                checks++; errors++;
                $display("FAIL ack_unexpected actual=0x%0h required=none", ack);
            end else begin
                mon_k = exp_ack.pop_front();
                check("ack_order", ack, 32'(1 << mon_k));
                check("busy_with_ack", busy, 1);
            end
        end
        if (lcd_e === 1'b1 && e_prev !== 1'b1) begin
            e_cnt = 1;
            if (exp_bus.size() == 0) begin
                checks++; errors++;
                $display("FAIL bus_unexpected actual=0x%0h required=no pulse", lcd_db);
            end else begin
                mon_b = exp_bus.pop_front();
                check("bus_rs", lcd_rs, mon_b.rs);
                check("bus_db", lcd_db, mon_b.db);
            end
        end else if (lcd_e === 1'b1) begin
            e_cnt++;
        end else if (e_prev === 1'b1 && rst !== 1'b1) begin
            check("e_width", e_cnt, TE);
        end
        if (busy_prev === 1'b1 && busy === 1'b0) t_busy_fall = cyc;
        e_prev    = lcd_e;
        busy_prev = busy;
    end

    task automatic wait_idle(input string name);
        int n = 0;
        do begin @(negedge clk2); #1; n++; end while (busy !== 1'b0 && n < 400);
        if (busy !== 1'b0) timeout(name);
    endtask

    task automatic wait_e(input string name, input logic v, output int t);
        int n = 0;
        do begin @(negedge clk2); #1; n++; end while (lcd_e !== v && n < 200);
        t = cyc;
        if (lcd_e !== v) timeout(name);
    endtask

    task automatic wait_ack(input string name, input int k, output int t);
        int n = 0;
        do begin @(negedge clk2); #1; n++; end while (ack[k] !== 1'b1 && n < 200);
        t = cyc;
        if (ack[k] !== 1'b1) timeout(name);
    endtask

    task automatic send(input int k, input logic r, input logic [7:0] d, input logic l, output int t_ack);
        exp_ack.push_back(k);
        exp_bus.push_back(bus_t'({r, d}));
        @(posedge clk2); #1;
        req[k] = 1'b1; rs[k] = r; data[8*k +: 8] = d; lock[k] = l;
        wait_ack("send_ack", k, t_ack);
        @(posedge clk2); #1;
        req[k] = 1'b0;
    endtask

    task automatic run_init();
        int t0, t;
        exp_bus.push_back(bus_t'({1'b0, 8'h38}));
        exp_bus.push_back(bus_t'({1'b0, 8'h38}));
        exp_bus.push_back(bus_t'({1'b0, 8'h0C}));
        exp_bus.push_back(bus_t'({1'b0, 8'h06}));
        exp_bus.push_back(bus_t'({1'b0, 8'h01}));
        rst = 1'b1;
        @(posedge clk2); @(posedge clk2); #1;
        check("rst_lcd_e", lcd_e, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_lcd_db", lcd_db, 0);
        check("rst_ack", ack, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 1);
        rst = 1'b0;
        t0 = cyc;
        wait_e("init_first_e", 1'b1, t);
        check("init_first_e_cycle", t - t0, TPW + TS + 1);
        wait_idle("init_idle");
        check("init_busy_fall", t_busy_fall - t0, TPW + 4 * SHORT_ENTRY + LONG_ENTRY);
        check("init_grant", grant, 0);
        check("init_bus_drained", exp_bus.size(), 0);
    endtask

    typedef struct { logic r; logic [7:0] d; logic lng; } wv_t;
    wv_t wvec[5] = '{
        '{1'b0, 8'h01, 1'b1}, '{1'b0, 8'h03, 1'b1}, '{1'b0, 8'h80, 1'b0},
        '{1'b1, 8'h01, 1'b0}, '{1'b0, 8'h04, 1'b0}
    };

    initial begin
        int ta, t, tr, base;

        run_init();

        // Contention: last owner resets to NREQ-1, so requester 0 goes first.
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NREQ; k++) begin
                exp_ack.push_back(k);
                exp_bus.push_back(bus_t'({1'b1, 8'(8'h30 + k)}));
            end
        base = n_acks;
        @(posedge clk2); #1;
        data = {8'h32, 8'h31, 8'h30}; rs = '1; req = '1;
        begin
            int n = 0;
            while (n_acks < base + 6 && n < 400) begin @(negedge clk2); #1; n++; end
            if (n_acks < base + 6) timeout("contention_acks");
        end
        @(posedge clk2); #1;
        req = '0;
        wait_idle("contention_idle");
        check("contention_grant", grant, 3'b100);

        // Single data write with timing checks.
        send(1, 1'b1, 8'h48, 1'b0, ta);
        wait_e("wr_rise", 1'b1, tr);
        check("wr_e_rise", tr - ta, TS + 1);
        wait_e("wr_fall", 1'b0, t);
        check("wr_e_high", t - tr, TE);
        check("wr_hold_db", lcd_db, 8'h48);
        check("wr_hold_rs", lcd_rs, 1);
        wait_idle("wr_idle");
        check("wr_cycle_gap", t_busy_fall - ta, TS + TE + TH + TSH + 1);
        check("wr_grant", grant, 3'b010);
        check("wr_db_idle", lcd_db, 8'h48);

        // Execution-wait selection.
        foreach (wvec[i]) begin
            send(0, wvec[i].r, wvec[i].d, 1'b0, ta);
            wait_idle("wait_sel_idle");
            check($sformatf("wait_gap_%0d", i), t_busy_fall - ta,
                  TS + TE + TH + (wvec[i].lng ? TL : TSH) + 1);
        end

        // Lock: requester 2 streams "ABC" while requester 0 is pending.
        exp_ack.push_back(2); exp_ack.push_back(2); exp_ack.push_back(2); exp_ack.push_back(0);
        exp_bus.push_back(bus_t'({1'b1, 8'h41}));
        exp_bus.push_back(bus_t'({1'b1, 8'h42}));
        exp_bus.push_back(bus_t'({1'b1, 8'h43}));
        exp_bus.push_back(bus_t'({1'b1, 8'h55}));
        @(posedge clk2); #1;
        data[7:0] = 8'h55; rs[0] = 1'b1; req[0] = 1'b1;
        data[23:16] = 8'h41; rs[2] = 1'b1; lock[2] = 1'b1; req[2] = 1'b1;
        wait_ack("lock_a", 2, t);
        @(posedge clk2); #1; data[23:16] = 8'h42;
        wait_ack("lock_b", 2, t);
        @(posedge clk2); #1; data[23:16] = 8'h43; lock[2] = 1'b0;
        wait_ack("lock_c", 2, t);
        @(posedge clk2); #1; req[2] = 1'b0;
        wait_ack("lock_0", 0, t);
        @(posedge clk2); #1; req[0] = 1'b0;
        wait_idle("lock_idle");
        check("lock_grant", grant, 3'b001);

        // Reset during the E pulse aborts and reruns the full init.
        send(1, 1'b1, 8'h5A, 1'b0, ta);
        wait_e("abort_rise", 1'b1, t);
        rst = 1'b1;
        @(posedge clk2); #1;
        check("abort_lcd_e", lcd_e, 0);
        check("abort_ack", ack, 0);
        check("abort_grant", grant, 0);
        check("abort_busy", busy, 1);
        run_init();

        check("ack_queue_empty", exp_ack.size(), 0);
        check("bus_queue_empty", exp_bus.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
